// File: rtl/ofdm_cp_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_cp_serializer
// Brief    : Captures one 32-point OFDM symbol and streams it on a valid/ready
//            port with the last CP_LEN samples prepended as a cyclic prefix.
// Revision : 1.0 - initial release
// ============================================================================
module ofdm_cp_serializer #(
    parameter int WORD_SIZE = 16,
    parameter int N         = 32,
    parameter int CP_LEN    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic [N*WORD_SIZE-1:0] i_re,
    input  logic [N*WORD_SIZE-1:0] i_im,
    output logic [WORD_SIZE-1:0]   o_re,
    output logic [WORD_SIZE-1:0]   o_im,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_sof,
    output logic                   o_eof,
    output logic                   o_busy,
    output logic                   o_overrun
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] C_START = (CP_LEN == 0) ? '0 : IDX_W'(N - CP_LEN);
    localparam logic [IDX_W-1:0] C_LAST  = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CP   = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [WORD_SIZE-1:0] r_buf_re [N];
    logic [WORD_SIZE-1:0] r_buf_im [N];
    logic [WORD_SIZE-1:0] r_re;
    logic [WORD_SIZE-1:0] r_im;
    logic                 r_valid;
    logic                 r_sof;
    logic                 r_eof;
    logic                 r_overrun;

    logic                 w_hs;
    logic                 w_accept;
    logic                 w_drop;
    state_t               w_nxt_state;
    logic [IDX_W-1:0]     w_nxt_idx;
    logic                 w_nxt_valid;
    logic                 w_nxt_sof;
    logic                 w_nxt_eof;
    logic [WORD_SIZE-1:0] w_nxt_re;
    logic [WORD_SIZE-1:0] w_nxt_im;

    assign w_hs     = r_valid && i_ready;
    // A load is taken when idle, or on the final beat so symbols run gapless.
    assign w_accept = i_load && ((r_state == S_IDLE) || (w_hs && r_eof));
    assign w_drop   = i_load && !w_accept;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        if (w_accept) begin
            w_nxt_state = (CP_LEN == 0) ? S_BODY : S_CP;
            w_nxt_idx   = C_START;
        end else if (w_hs) begin
            w_nxt_idx = r_idx + 1'b1;
            if (r_idx == C_LAST) begin
                w_nxt_state = (r_state == S_CP) ? S_BODY : S_IDLE;
            end
        end

        w_nxt_valid = (w_nxt_state != S_IDLE);
        w_nxt_sof   = w_nxt_valid &&
                      (((w_nxt_state == S_CP) && (w_nxt_idx == C_START)) ||
                       ((CP_LEN == 0) && (w_nxt_state == S_BODY) && (w_nxt_idx == '0)));
        w_nxt_eof   = w_nxt_valid && (w_nxt_state == S_BODY) && (w_nxt_idx == C_LAST);

        // The buffer is being overwritten on an accepted load, so the first
        // sample comes straight from the input bus.
        w_nxt_re = '0;
        w_nxt_im = '0;
        if (w_nxt_valid) begin
            if (w_accept) begin
                w_nxt_re = i_re[int'(w_nxt_idx)*WORD_SIZE +: WORD_SIZE];
                w_nxt_im = i_im[int'(w_nxt_idx)*WORD_SIZE +: WORD_SIZE];
            end else begin
                w_nxt_re = r_buf_re[w_nxt_idx];
                w_nxt_im = r_buf_im[w_nxt_idx];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_re      <= '0;
            r_im      <= '0;
            r_valid   <= 1'b0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
            r_overrun <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_buf_re[k] <= '0;
                r_buf_im[k] <= '0;
            end
        end else begin
            r_state   <= w_nxt_state;
            r_idx     <= w_nxt_idx;
            r_re      <= w_nxt_re;
            r_im      <= w_nxt_im;
            r_valid   <= w_nxt_valid;
            r_sof     <= w_nxt_sof;
            r_eof     <= w_nxt_eof;
            r_overrun <= w_drop;
            if (w_accept) begin
                for (int k = 0; k < N; k++) begin
                    r_buf_re[k] <= i_re[k*WORD_SIZE +: WORD_SIZE];
                    r_buf_im[k] <= i_im[k*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    assign o_re      = r_re;
    assign o_im      = r_im;
    assign o_valid   = r_valid;
    assign o_sof     = r_sof;
    assign o_eof     = r_eof;
    assign o_busy    = r_valid;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_cp_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofdm_cp_serializer
// Brief    : Self-checking bench; two instances (CP_LEN 8 and 0) are compared
//            every cycle against a queue-based expected-beat model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofdm_cp_serializer;

    localparam int W = 16;
    localparam int N = 32;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         sof;
        logic         eof;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] re_bus;
    logic [N*W-1:0] im_bus;
    logic [1:0]     load;
    logic [1:0]     ready;

    logic [W-1:0] dut_re    [2];
    logic [W-1:0] dut_im    [2];
    logic         dut_valid [2];
    logic         dut_sof   [2];
    logic         dut_eof   [2];
    logic         dut_busy  [2];
    logic         dut_ovr   [2];

    beat_t      q [2][$];
    logic [1:0] exp_ovr;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    ofdm_cp_serializer #(.WORD_SIZE(W), .N(N), .CP_LEN(8)) u_dut_cp (
        .i_clk(clk), .i_rst(rst), .i_load(load[0]), .i_re(re_bus), .i_im(im_bus),
        .o_re(dut_re[0]), .o_im(dut_im[0]), .o_valid(dut_valid[0]), .i_ready(ready[0]),
        .o_sof(dut_sof[0]), .o_eof(dut_eof[0]), .o_busy(dut_busy[0]), .o_overrun(dut_ovr[0])
    );

    ofdm_cp_serializer #(.WORD_SIZE(W), .N(N), .CP_LEN(0)) u_dut_nocp (
        .i_clk(clk), .i_rst(rst), .i_load(load[1]), .i_re(re_bus), .i_im(im_bus),
        .o_re(dut_re[1]), .o_im(dut_im[1]), .o_valid(dut_valid[1]), .i_ready(ready[1]),
        .o_sof(dut_sof[1]), .o_eof(dut_eof[1]), .o_busy(dut_busy[1]), .o_overrun(dut_ovr[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cp_of(input int c);
        return (c == 0) ? 8 : 0;
    endfunction

    // mode 0: re=k, im=-k; mode 1: re=100+k, im=-(100+k); mode 2: random
    task automatic set_data(input int mode);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       begin re_bus[k*W +: W] = W'(k);       im_bus[k*W +: W] = W'(-k);       end
                1:       begin re_bus[k*W +: W] = W'(100 + k); im_bus[k*W +: W] = W'(-(100 + k)); end
                default: begin re_bus[k*W +: W] = W'($urandom); im_bus[k*W +: W] = W'($urandom); end
            endcase
        end
    endtask

    // Expected symbol: last cp samples, then the whole symbol in order.
    task automatic push_symbol(input int c);
        int    cp;
        int    k;
        beat_t b;
        cp = cp_of(c);
        for (int j = 0; j < N + cp; j++) begin
            k     = (j < cp) ? (N - cp + j) : (j - cp);
            b.re  = re_bus[k*W +: W];
            b.im  = im_bus[k*W +: W];
            b.sof = (j == 0);
            b.eof = (j == N + cp - 1);
            q[c].push_back(b);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q[0].delete();
            q[1].delete();
            exp_ovr <= 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                automatic bit busy = (q[c].size() != 0);
                automatic bit hs   = busy && ready[c];
                automatic bit last = hs && q[c][0].eof;
                automatic bit acc  = load[c] && (!busy || last);
                exp_ovr[c] <= load[c] && !acc;
                if (hs) void'(q[c].pop_front());
                if (acc) push_symbol(c);
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            automatic bit    ev = (q[c].size() != 0);
            automatic beat_t b  = ev ? q[c][0] : '0;
            chk($sformatf("c%0d valid", c), 32'(dut_valid[c]), 32'(ev));
            chk($sformatf("c%0d busy", c),  32'(dut_busy[c]),  32'(ev));
            chk($sformatf("c%0d re", c),    32'(dut_re[c]),    32'(b.re));
            chk($sformatf("c%0d im", c),    32'(dut_im[c]),    32'(b.im));
            chk($sformatf("c%0d sof", c),   32'(dut_sof[c]),   32'(b.sof));
            chk($sformatf("c%0d eof", c),   32'(dut_eof[c]),   32'(b.eof));
            chk($sformatf("c%0d ovr", c),   32'(dut_ovr[c]),   32'(exp_ovr[c]));
        end
    end

    initial begin
        rst   = 1'b1;
        load  = 2'b00;
        ready = 2'b11;
        set_data(0);
        repeat (3) @(negedge clk);
        chk("reset valid", 32'(dut_valid[0]), 32'd0);
        chk("reset re", 32'(dut_re[0]), 32'd0);
        rst = 1'b0;

        // basic stream on both instances
        load = 2'b11;
        @(negedge clk);
        load = 2'b00;
        chk("basic sof", 32'(dut_sof[0]), 32'd1);
        chk("basic first re", 32'(dut_re[0]), 32'd24);
        chk("nocp sof", 32'(dut_sof[1]), 32'd1);
        chk("nocp first re", 32'(dut_re[1]), 32'd0);
        repeat (45) @(negedge clk);
        chk("basic end valid", 32'(dut_valid[0]), 32'd0);
        chk("basic end re", 32'(dut_re[0]), 32'd0);

        // backpressure with ready pattern 1,0,0
        load[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0;
        for (int i = 0; i < 150; i++) begin
            ready[0] = (i % 3 == 0);
            @(negedge clk);
        end
        ready[0] = 1'b1;
        repeat (5) @(negedge clk);

        // back-to-back load on the eof handshake
        load[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0;
        for (int i = 0; i < 100 && !(dut_valid[0] && dut_eof[0]); i++) @(negedge clk);
        chk("b2b eof seen", 32'(dut_eof[0]), 32'd1);
        set_data(1);
        load[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0;
        chk("b2b sof", 32'(dut_sof[0]), 32'd1);
        chk("b2b re", 32'(dut_re[0]), 32'd124);
        chk("b2b no ovr", 32'(dut_ovr[0]), 32'd0);
        repeat (45) @(negedge clk);

        // overrun: extra load at beat 10
        set_data(0);
        load[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0;
        repeat (9) @(negedge clk);
        set_data(2);
        load[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0;
        chk("ovr pulse", 32'(dut_ovr[0]), 32'd1);
        @(negedge clk);
        chk("ovr one cycle", 32'(dut_ovr[0]), 32'd0);
        repeat (50) @(negedge clk);
        chk("ovr no follow", 32'(dut_valid[0]), 32'd0);

        // reset at beat 20, then a fresh symbol
        set_data(0);
        load[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst valid", 32'(dut_valid[0]), 32'd0);
        chk("midrst eof", 32'(dut_eof[0]), 32'd0);
        set_data(2);
        load[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0;
        chk("midrst restart sof", 32'(dut_sof[0]), 32'd1);
        repeat (45) @(negedge clk);

        // randomized loads, data and backpressure
        for (int i = 0; i < 800; i++) begin
            set_data(2);
            for (int c = 0; c < 2; c++) begin
                ready[c] = ($urandom_range(0, 3) != 0);
                load[c]  = ($urandom_range(0, 15) == 0);
            end
            @(negedge clk);
        end
        load  = 2'b00;
        ready = 2'b11;
        repeat (60) @(negedge clk);
        chk("drain cp", 32'(q[0].size()), 32'd0);
        chk("drain nocp", 32'(q[1].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
